// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback arbiter merging pipeline and long-latency results.
// Optional macro WB_BYPASS_EN: LL result skips an empty FIFO when pipe idle.
//
// Ports:
//   clk, rst                  clock, async active-high reset
//   wb_valid/wb_rd/wb_data    pipeline result (never stalled)
//   ll_valid/ll_ready         LL result handshake
//   ll_rd/ll_data             LL result payload
//   iss_valid/iss_rd          LL issue, marks iss_rd pending
//   chk_rs1/chk_rs2/chk_rd    decode operands checked for hazards
//   hazard                    combinational scoreboard hit
//   WE3/AD3/WD3               registered register file write port
module wb_arbiter #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int LL_DEPTH      = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_valid,
  input  logic [ADDRESS_WIDTH-1:0] wb_rd,
  input  logic [DATA_WIDTH-1:0]    wb_data,
  input  logic                     ll_valid,
  output logic                     ll_ready,
  input  logic [ADDRESS_WIDTH-1:0] ll_rd,
  input  logic [DATA_WIDTH-1:0]    ll_data,
  input  logic                     iss_valid,
  input  logic [ADDRESS_WIDTH-1:0] iss_rd,
  input  logic [ADDRESS_WIDTH-1:0] chk_rs1,
  input  logic [ADDRESS_WIDTH-1:0] chk_rs2,
  input  logic [ADDRESS_WIDTH-1:0] chk_rd,
  output logic                     hazard,
  output logic                     WE3,
  output logic [ADDRESS_WIDTH-1:0] AD3,
  output logic [DATA_WIDTH-1:0]    WD3
);

  localparam int NREG = 2 ** ADDRESS_WIDTH;
  localparam int PW   = (LL_DEPTH > 1) ? $clog2(LL_DEPTH) : 1;
  localparam int CW   = $clog2(LL_DEPTH + 1);
  localparam logic [PW-1:0] PLAST = PW'(LL_DEPTH - 1);
  localparam logic [CW-1:0] CFULL = CW'(LL_DEPTH);

  logic [ADDRESS_WIDTH-1:0] mem_rd_q [LL_DEPTH];
  logic [DATA_WIDTH-1:0]    mem_dat_q [LL_DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [NREG-1:0] pend_q, pend_d;

  logic                     we_q, we_d;
  logic [ADDRESS_WIDTH-1:0] ad_q, ad_d;
  logic [DATA_WIDTH-1:0]    wd_q, wd_d;
  // tag: 1 when the held write came from the LL path
  logic                     tag_q, tag_d;

  logic empty;
  logic sel_pipe;
  logic sel_fifo;
  logic sel_byp;
  logic push;
  logic pop;

  assign empty    = (cnt_q == '0);
  assign ll_ready = (cnt_q != CFULL);

  assign sel_pipe = wb_valid;
  assign sel_fifo = !wb_valid && !empty;
`ifdef WB_BYPASS_EN
  assign sel_byp  = !wb_valid && empty && ll_valid;
`else
  assign sel_byp  = 1'b0;
`endif

  assign pop  = sel_fifo;
  // ll_ready already blocks pushes into a full FIFO
  assign push = ll_valid && ll_ready && !sel_byp;

  assign hazard = pend_q[chk_rs1] | pend_q[chk_rs2] | pend_q[chk_rd];

  assign WE3 = we_q;
  assign AD3 = ad_q;
  assign WD3 = wd_q;

  always_comb begin
    we_d  = 1'b0;
    ad_d  = ad_q;
    wd_d  = wd_q;
    tag_d = 1'b0;
    unique case (1'b1)
      sel_pipe: begin
        we_d  = (wb_rd != '0);
        ad_d  = wb_rd;
        wd_d  = wb_data;
        tag_d = 1'b0;
      end
      sel_fifo: begin
        we_d  = (mem_rd_q[rd_ptr_q] != '0);
        ad_d  = mem_rd_q[rd_ptr_q];
        wd_d  = mem_dat_q[rd_ptr_q];
        tag_d = 1'b1;
      end
      sel_byp: begin
        we_d  = (ll_rd != '0);
        ad_d  = ll_rd;
        wd_d  = ll_data;
        tag_d = 1'b1;
      end
      default: begin
        we_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PLAST) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PLAST) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Clear happens on the edge the LL write retires; set is applied last
  // so a same-cycle reissue keeps the register pending.
  always_comb begin
    pend_d = pend_q;
    if (we_q && tag_q) begin
      pend_d[ad_q] = 1'b0;
    end
    if (iss_valid) begin
      pend_d[iss_rd] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd_q[wr_ptr_q]  <= ll_rd;
      mem_dat_q[wr_ptr_q] <= ll_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      pend_q   <= '0;
      we_q     <= 1'b0;
      ad_q     <= '0;
      wd_q     <= '0;
      tag_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      we_q     <= we_d;
      ad_q     <= ad_d;
      wd_q     <= wd_d;
      tag_q    <= tag_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed self-checking bench for wb_arbiter
// (default build, LL_DEPTH=2).
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ll_valid;
  logic        ll_ready;
  logic [4:0]  ll_rd;
  logic [31:0] ll_data;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [4:0]  chk_rs1;
  logic [4:0]  chk_rs2;
  logic [4:0]  chk_rd;
  logic        hazard;
  logic        WE3;
  logic [4:0]  AD3;
  logic [31:0] WD3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_arbiter #(
    .ADDRESS_WIDTH(5),
    .DATA_WIDTH(32),
    .LL_DEPTH(2)
  ) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .ll_valid(ll_valid), .ll_ready(ll_ready),
    .ll_rd(ll_rd), .ll_data(ll_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd),
    .hazard(hazard),
    .WE3(WE3), .AD3(AD3), .WD3(WD3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_valid = 0; wb_rd = 0; wb_data = 0;
    ll_valid = 0; ll_rd = 0; ll_data = 0;
    iss_valid = 0; iss_rd = 0;
    chk_rs1 = 0; chk_rs2 = 0; chk_rd = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    #3;
    checks++;
    if ({WE3, AD3, WD3} !== 38'h0) begin
      failures++;
      $display("FAIL reset_out got %b/%0d/%h want 0/0/0", WE3, AD3, WD3);
    end
    checks++;
    if ({ll_ready, hazard} !== 2'b10) begin
      failures++;
      $display("FAIL reset_flags got rdy=%b hz=%b want 1/0", ll_ready, hazard);
    end
    step();
    rst = 0;
    step();
  endtask

  task automatic test_pipe_write();
    wb_valid = 1; wb_rd = 3; wb_data = 32'hDEADBEEF;
    step();
    idle();
    checks++;
    if ({WE3, AD3, WD3} !== {1'b1, 5'd3, 32'hDEADBEEF}) begin
      failures++;
      $display("FAIL pipe_write got %b/%0d/%h want 1/3/deadbeef", WE3, AD3, WD3);
    end
    step();
    checks++;
    if ({WE3, AD3} !== {1'b0, 5'd3}) begin
      failures++;
      $display("FAIL pipe_idle got %b/%0d want 0/3", WE3, AD3);
    end
  endtask

  task automatic test_conflict();
    wb_valid = 1; wb_rd = 4; wb_data = 32'h11;
    ll_valid = 1; ll_rd = 7; ll_data = 32'h22;
    step();
    idle();
    checks++;
    if ({WE3, AD3, WD3} !== {1'b1, 5'd4, 32'h11}) begin
      failures++;
      $display("FAIL conflict_pipe got %b/%0d/%h want 1/4/11", WE3, AD3, WD3);
    end
    step();
    checks++;
    if ({WE3, AD3, WD3} !== {1'b1, 5'd7, 32'h22}) begin
      failures++;
      $display("FAIL conflict_ll got %b/%0d/%h want 1/7/22", WE3, AD3, WD3);
    end
    step();
    checks++;
    if (WE3 !== 1'b0) begin
      failures++;
      $display("FAIL conflict_done got WE3=%b want 0", WE3);
    end
  endtask

  task automatic test_scoreboard();
    iss_valid = 1; iss_rd = 9;
    step();
    idle();
    chk_rs2 = 9;
    #1;
    checks++;
    if (hazard !== 1'b1) begin
      failures++;
      $display("FAIL sb_set got hazard=%b want 1", hazard);
    end
    chk_rs2 = 0; chk_rd = 9;
    #1;
    checks++;
    if (hazard !== 1'b1) begin
      failures++;
      $display("FAIL sb_waw got hazard=%b want 1", hazard);
    end
    chk_rd = 0; chk_rs1 = 8;
    #1;
    checks++;
    if (hazard !== 1'b0) begin
      failures++;
      $display("FAIL sb_other got hazard=%b want 0", hazard);
    end
    chk_rs1 = 0; chk_rs2 = 9;
    ll_valid = 1; ll_rd = 9; ll_data = 32'h99;
    step();
    ll_valid = 0; ll_rd = 0; ll_data = 0;
    checks++;
    if ({WE3, hazard} !== 2'b01) begin
      failures++;
      $display("FAIL sb_queued got we=%b hz=%b want 0/1", WE3, hazard);
    end
    step();
    checks++;
    if ({WE3, AD3, WD3, hazard} !== {1'b1, 5'd9, 32'h99, 1'b1}) begin
      failures++;
      $display("FAIL sb_write got %b/%0d/%h hz=%b want 1/9/99 hz=1",
               WE3, AD3, WD3, hazard);
    end
    step();
    checks++;
    if (hazard !== 1'b0) begin
      failures++;
      $display("FAIL sb_clear got hazard=%b want 0", hazard);
    end
    idle();
  endtask

  task automatic test_fifo_full();
    wb_valid = 1; wb_rd = 1; wb_data = 32'h1;
    ll_valid = 1; ll_rd = 10; ll_data = 32'hA;
    step();
    checks++;
    if (ll_ready !== 1'b1) begin
      failures++;
      $display("FAIL full_one got ll_ready=%b want 1", ll_ready);
    end
    ll_rd = 11; ll_data = 32'hB;
    step();
    checks++;
    if (ll_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_two got ll_ready=%b want 0", ll_ready);
    end
    ll_rd = 12; ll_data = 32'hC;
    step();
    ll_valid = 0;
    checks++;
    if ({WE3, AD3, WD3, ll_ready} !== {1'b1, 5'd1, 32'h1, 1'b0}) begin
      failures++;
      $display("FAIL full_hold got %b/%0d/%h rdy=%b want 1/1/1 rdy=0",
               WE3, AD3, WD3, ll_ready);
    end
    idle();
    step();
    checks++;
    if ({WE3, AD3, WD3, ll_ready} !== {1'b1, 5'd10, 32'hA, 1'b1}) begin
      failures++;
      $display("FAIL drain_a got %b/%0d/%h rdy=%b want 1/10/a rdy=1",
               WE3, AD3, WD3, ll_ready);
    end
    step();
    checks++;
    if ({WE3, AD3, WD3} !== {1'b1, 5'd11, 32'hB}) begin
      failures++;
      $display("FAIL drain_b got %b/%0d/%h want 1/11/b", WE3, AD3, WD3);
    end
    step();
    checks++;
    if ({WE3, ll_ready} !== 2'b01) begin
      failures++;
      $display("FAIL drain_end got we=%b rdy=%b want 0/1", WE3, ll_ready);
    end
  endtask

  task automatic test_x0();
    ll_valid = 1; ll_rd = 0; ll_data = 32'h55;
    iss_valid = 1; iss_rd = 0;
    step();
    idle();
    checks++;
    if (hazard !== 1'b0) begin
      failures++;
      $display("FAIL x0_pending got hazard=%b want 0", hazard);
    end
    step();
    checks++;
    if (WE3 !== 1'b0) begin
      failures++;
      $display("FAIL x0_write got WE3=%b want 0", WE3);
    end
    ll_valid = 1; ll_rd = 13; ll_data = 32'h77;
    step();
    idle();
    step();
    checks++;
    if ({WE3, AD3, WD3} !== {1'b1, 5'd13, 32'h77}) begin
      failures++;
      $display("FAIL x0_popped got %b/%0d/%h want 1/13/77", WE3, AD3, WD3);
    end
    step();
  endtask

  task automatic test_reset_midstream();
    iss_valid = 1; iss_rd = 5;
    step();
    iss_valid = 0; iss_rd = 0;
    wb_valid = 1; wb_rd = 2; wb_data = 32'h2;
    ll_valid = 1; ll_rd = 6; ll_data = 32'h6;
    step();
    ll_rd = 8; ll_data = 32'h8;
    step();
    ll_valid = 0;
    chk_rs1 = 5;
    #1;
    checks++;
    if ({WE3, hazard, ll_ready} !== 3'b110) begin
      failures++;
      $display("FAIL pre_reset got we=%b hz=%b rdy=%b want 1/1/0",
               WE3, hazard, ll_ready);
    end
    rst = 1;
    #1;
    checks++;
    if ({WE3, hazard} !== 2'b00) begin
      failures++;
      $display("FAIL mid_reset got we=%b hz=%b want 0/0", WE3, hazard);
    end
    step();
    rst = 0;
    idle();
    chk_rs1 = 5;
    step();
    checks++;
    if ({WE3, hazard, ll_ready} !== 3'b001) begin
      failures++;
      $display("FAIL post_reset got we=%b hz=%b rdy=%b want 0/0/1",
               WE3, hazard, ll_ready);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_pipe_write();
    test_conflict();
    test_scoreboard();
    test_fifo_full();
    test_x0();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
